seletor_sequencial: RTL and testbench
=====================================

# seletor_sequencial

Upstream stage of the 2-bit decoder: turns a raw push-button (and, optionally, a free-running timer) into the 2-bit selection code that drives the decoder's `p_Input`. Synchronizes and debounces the button, advances a wrapping 2-bit code up or down on each clean press, and flags every code change with a one-cycle pulse. Sits between the board switches/buttons and the decoder feeding the LEDs.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive cycles a synchronized level must persist before it is accepted (≥2).
- `AUTO_PERIOD`, default 8: cycles between automatic steps in auto mode (≥2; used only with `SEQ_AUTO_EN`).

- `p_Clock`  in  1  sole clock, rising edge.
- `p_Reset`  in  1  synchronous, active-low reset.
- `p_Button`  in  1  raw, asynchronous, bouncy push-button, active-high.
- `p_Dir`  in  1  step direction: 0 = increment, 1 = decrement; sampled when a step is taken.
- `p_Auto`  in  1  auto-step request (level); ignored without `SEQ_AUTO_EN`.
- `p_Code`  out  2  current selection code, to decoder `p_Input`.
- `p_Step`  out  1  one-cycle pulse, high in the cycle `p_Code` shows a new value.
- `p_Stable`  out  1  debounced button level.

## Operation
- Synchronizer: two flops on `p_Button` → `sync`.
- Debouncer: counter `db_cnt`, width ⌈log2(DEBOUNCE_CYCLES)⌉. If `sync == p_Stable`, `db_cnt` ← 0. Otherwise, if `db_cnt == DEBOUNCE_CYCLES-1`, `p_Stable` ← `sync` and `db_cnt` ← 0; else `db_cnt` increments.
- Press event: `p_Stable` rising edge, via registered previous value.
- FSM states:
  - `S_IDLE`: press event → take step, go to `S_HELD`; `p_Auto`=1 (macro on) → `S_AUTO`, prescaler cleared.
  - `S_HELD`: no repeat while held; `p_Stable`=0 → `S_IDLE`.
  - `S_AUTO`: prescaler counts 0..AUTO_PERIOD-1; at terminal count take step and wrap to 0. `p_Auto`=0 → `S_IDLE` with no step that cycle. Press events in `S_AUTO` also take a step and clear the prescaler.
- Step: `p_Code` ← `p_Code`+1 (`p_Dir`=0) or `p_Code`−1 (`p_Dir`=1), modulo 4. 3→0 up, 0→3 down.
- Simultaneous press event and auto terminal count: exactly one step, prescaler cleared.

## Timing
- Reset (`p_Reset`=0 at an edge) overrides everything, including mid-debounce and mid-auto. Reset values: `p_Code`=2'b00, `p_Step`=0, `p_Stable`=0, `db_cnt`=0, prescaler=0, state `S_IDLE`, synchronizer flops 0.
- Press latency: `p_Button` rises before edge 1 and stays high → `sync` high after edge 2 → `p_Stable` high after edge 2+DEBOUNCE_CYCLES → `p_Code`/`p_Step` update after edge 3+DEBOUNCE_CYCLES. With the default this is edge 7.
- Release is debounced identically; no step on release.
- Pulse on `sync` shorter than DEBOUNCE_CYCLES cycles: no change to `p_Stable`, no step.
- `p_Step` is high for exactly one cycle per step. Consecutive auto steps are AUTO_PERIOD cycles apart.

## Configuration
- `SEQ_AUTO_EN` defined: prescaler, `S_AUTO`, and `p_Auto` handling compiled in as above.
- `SEQ_AUTO_EN` undefined: no prescaler or `S_AUTO`. `p_Auto` is unused and the FSM is `S_IDLE`/`S_HELD` only. Code advances solely on button presses.

## Test plan
- Reset: hold `p_Reset`=0 three cycles with `p_Button`=1 → `p_Code`=00, `p_Step`=0, `p_Stable`=0 throughout; release → first step after edge 7.
- Clean press, `p_Dir`=0, defaults: four presses from 00 → `p_Code` 01, 10, 11, 00, each with a single-cycle `p_Step` 7 edges after the rise; held button → no further steps.
- Bounce: `p_Button` toggled 1,0,1,0 each cycle, then steady 1 → exactly one step; a 3-cycle glitch alone → no step.
- Down wrap: `p_Dir`=1 from 00 → 11, then 10.
- Auto (`SEQ_AUTO_EN`): `p_Auto`=1 from code 00 → `p_Step` every 8 cycles, codes 01, 10, 11, 00. A press landing on a terminal count → one step only. Drop `p_Auto` → steps stop.
- Reset mid-auto: assert `p_Reset` between ticks → `p_Code`=00, state `S_IDLE`, no pending step after release.

Source files
------------

// File: rtl/seletor_sequencial.sv
// seletor_sequencial: debounced push-button to wrapping 2-bit selection code with step pulse.
// Define SEQ_AUTO_EN to compile in the auto-step prescaler and the S_AUTO state.
module seletor_sequencial #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int AUTO_PERIOD     = 8
) (
    input  logic       p_Clock,
    input  logic       p_Reset,
    input  logic       p_Button,
    input  logic       p_Dir,
    input  logic       p_Auto,
    output logic [1:0] p_Code,
    output logic       p_Step,
    output logic       p_Stable
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] DB_MAX = CW'(DEBOUNCE_CYCLES - 1);
`ifdef SEQ_AUTO_EN
    localparam int PW = (AUTO_PERIOD > 1) ? $clog2(AUTO_PERIOD) : 1;
    localparam logic [PW-1:0] AP_MAX = PW'(AUTO_PERIOD - 1);
    typedef enum logic [1:0] {S_IDLE, S_HELD, S_AUTO} state_t;
    logic [PW-1:0] presc_q, presc_d;
`else
    typedef enum logic {S_IDLE, S_HELD} state_t;
    logic unused_auto;
    assign unused_auto = p_Auto;
`endif
    state_t        state_q, state_d;
    logic          meta_q, sync_q, stable_q, stable_d, prev_q, step_q, step_d;
    logic          press, take;
    logic [CW-1:0] db_cnt_q, db_cnt_d;
    logic [1:0]    code_q, code_d;

    assign press    = stable_q & ~prev_q;
    assign p_Code   = code_q;
    assign p_Step   = step_q;
    assign p_Stable = stable_q;

    always_comb begin
        stable_d = stable_q;
        db_cnt_d = '0;
        if (sync_q != stable_q) begin
            stable_d = (db_cnt_q == DB_MAX) ? sync_q : stable_q;
            db_cnt_d = (db_cnt_q == DB_MAX) ? '0 : db_cnt_q + 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        take    = 1'b0;
`ifdef SEQ_AUTO_EN
        presc_d = presc_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (press) begin
                    take    = 1'b1;
                    state_d = S_HELD;
                end
`ifdef SEQ_AUTO_EN
                else if (p_Auto) begin
                    state_d = S_AUTO;
                    presc_d = '0;
                end
`endif
            end
            S_HELD: state_d = stable_q ? S_HELD : S_IDLE;
`ifdef SEQ_AUTO_EN
            // A press coinciding with the terminal count yields a single step.
            S_AUTO: begin
                if (!p_Auto) begin
                    state_d = S_IDLE;
                end else if (press || presc_q == AP_MAX) begin
                    take    = 1'b1;
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
        step_d = take;
        code_d = take ? (p_Dir ? code_q - 2'd1 : code_q + 2'd1) : code_q;
    end

    always_ff @(posedge p_Clock) begin
        if (!p_Reset) begin
            meta_q   <= 1'b0;
            sync_q   <= 1'b0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            db_cnt_q <= '0;
            state_q  <= S_IDLE;
            code_q   <= 2'b00;
            step_q   <= 1'b0;
`ifdef SEQ_AUTO_EN
            presc_q  <= '0;
`endif
        end else begin
            meta_q   <= p_Button;
            sync_q   <= meta_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            db_cnt_q <= db_cnt_d;
            state_q  <= state_d;
            code_q   <= code_d;
            step_q   <= step_d;
`ifdef SEQ_AUTO_EN
            presc_q  <= presc_d;
`endif
        end
    end
endmodule

// File: tb/tb_seletor_sequencial.sv
// tb_seletor_sequencial: table, hand-sequence and random checks of seletor_sequencial.
// Auto-step sequences run only when SEQ_AUTO_EN is defined.
module tb_seletor_sequencial;
    localparam int D = 4;
    localparam int P = 8;
`ifdef SEQ_AUTO_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0, rst_n = 1'b0, btn = 1'b0, dir = 1'b0, auto_r = 1'b0;
    logic [1:0] code;
    logic       step, stable;

    seletor_sequencial #(.DEBOUNCE_CYCLES(D), .AUTO_PERIOD(P)) dut (
        .p_Clock(clk), .p_Reset(rst_n), .p_Button(btn), .p_Dir(dir), .p_Auto(auto_r),
        .p_Code(code), .p_Step(step), .p_Stable(stable)
    );

    always #5 clk = ~clk;

    int n_cmp = 0, n_bad = 0, steps_seen = 0;

    // Reference: level accepted after D consecutive disagreeing samples; every accepted
    // rising level is one step; auto mode steps once per P elapsed cycles.
    bit m_s1, m_sync, m_stable, m_prev, m_step;
    int m_run, m_code, m_mode, m_elapsed;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic model_edge();
        bit o_sync, o_stable, o_prev, press, take;
        o_sync = m_sync; o_stable = m_stable; o_prev = m_prev;
        if (!rst_n) begin
            m_s1 = 0; m_sync = 0; m_stable = 0; m_prev = 0; m_step = 0;
            m_run = 0; m_code = 0; m_mode = 0; m_elapsed = 0;
            return;
        end
        press = o_stable && !o_prev;
        take  = 0;
        m_sync = m_s1;
        m_s1   = btn;
        if (o_sync != o_stable) begin
            m_run++;
            if (m_run == D) begin m_stable = o_sync; m_run = 0; end
        end else m_run = 0;
        m_prev = o_stable;
        if (m_mode == 0) begin
            if (press) begin take = 1; m_mode = 1; end
            else if (AUTO && auto_r) begin m_mode = 2; m_elapsed = 0; end
        end else if (m_mode == 1) begin
            if (!o_stable) m_mode = 0;
        end else begin
            if (!auto_r) m_mode = 0;
            else if (press) begin take = 1; m_elapsed = 0; end
            else begin
                m_elapsed++;
                if (m_elapsed == P) begin take = 1; m_elapsed = 0; end
            end
        end
        if (take) m_code = (m_code + (dir ? 3 : 1)) % 4;
        m_step = take;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        chk("code", 32'(code), 32'(m_code));
        chk("step", 32'(step), 32'(m_step));
        chk("stable", 32'(stable), 32'(m_stable));
        if (step === 1'b1) steps_seen++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    typedef struct {
        bit         dir;
        int         hold;
        logic [1:0] exp_code;
        int         exp_steps;
    } vec_t;
    vec_t tbl[10];

    initial begin
        int first, last, k;
        tbl[0] = '{0, 10, 2'b10, 1};
        tbl[1] = '{0, 10, 2'b11, 1};
        tbl[2] = '{0, 10, 2'b00, 1};
        tbl[3] = '{1, 10, 2'b11, 1};
        tbl[4] = '{1, 10, 2'b10, 1};
        tbl[5] = '{0, 3,  2'b10, 0};
        tbl[6] = '{0, 4,  2'b11, 1};
        tbl[7] = '{1, 4,  2'b10, 1};
        tbl[8] = '{1, 2,  2'b10, 0};
        tbl[9] = '{1, 10, 2'b01, 1};

        btn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rst_code", 32'(code), 0);
            chk("rst_step", 32'(step), 0);
            chk("rst_stable", 32'(stable), 0);
        end
        rst_n = 1'b1;
        first = 0;
        steps_seen = 0;
        for (int i = 1; i <= 20; i++) begin
            tick();
            if (step === 1'b1 && first == 0) first = i;
        end
        chk("press_latency", 32'(first), 7);
        chk("held_steps", 32'(steps_seen), 1);
        chk("first_code", 32'(code), 1);
        btn = 1'b0;
        ticks(12);

        for (int v = 0; v < 10; v++) begin
            dir = tbl[v].dir;
            steps_seen = 0;
            btn = 1'b1;
            ticks(tbl[v].hold);
            btn = 1'b0;
            ticks(12);
            chk($sformatf("tbl%0d_code", v), 32'(code), 32'(tbl[v].exp_code));
            chk($sformatf("tbl%0d_steps", v), 32'(steps_seen), 32'(tbl[v].exp_steps));
        end

        steps_seen = 0;
        dir = 1'b0;
        btn = 1'b1; tick(); btn = 1'b0; tick();
        btn = 1'b1; tick(); btn = 1'b0; tick();
        btn = 1'b1; ticks(10);
        btn = 1'b0; ticks(12);
        chk("bounce_steps", 32'(steps_seen), 1);
        chk("bounce_code", 32'(code), 2);

`ifdef SEQ_AUTO_EN
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        auto_r = 1'b1;
        tick();
        last = 0; k = 0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            if (step === 1'b1) begin
                k++;
                chk("auto_gap", 32'(i - last), P);
                chk("auto_code", 32'(code), 32'(k % 4));
                last = i;
            end
        end
        chk("auto_steps", 32'(k), 4);
        tick();
        btn = 1'b1;
        steps_seen = 0;
        ticks(14);
        chk("coincide_steps", 32'(steps_seen), 1);
        btn = 1'b0;
        ticks(6);
        auto_r = 1'b0;
        steps_seen = 0;
        ticks(20);
        chk("auto_off_steps", 32'(steps_seen), 0);
        auto_r = 1'b1;
        ticks(12);
        rst_n = 1'b0;
        tick();
        chk("mid_auto_rst_code", 32'(code), 0);
        rst_n = 1'b1;
        auto_r = 1'b0;
        steps_seen = 0;
        ticks(20);
        chk("post_rst_steps", 32'(steps_seen), 0);
`endif

        for (int b = 0; b < 300; b++) begin
            btn = 1'($urandom_range(0, 1));
            dir = 1'($urandom_range(0, 1));
            if (AUTO && $urandom_range(0, 9) == 0) auto_r = ~auto_r;
            rst_n = ($urandom_range(0, 99) != 0);
            ticks($urandom_range(1, 10));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
